// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter that multiplexes NREQ requesters onto one shared memory port.
// A granted access is latched and held on the port until mem_ready or the wait-state timeout.
module mem_request_arbiter #(
   parameter int NREQ     = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   halt,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        wen,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*DATA_W-1:0] wdata,
   output logic [NREQ-1:0]        done,
   output logic [DATA_W-1:0]      rdata,
   output logic                   timeout_err,
   output logic                   mem_ren,
   output logic                   mem_wen,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_ready
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t             state_r;
   logic [PTR_W-1:0]   ptr_r;
   logic [PTR_W-1:0]   win_r;
   logic               wen_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [DATA_W-1:0]  wdata_r;
   logic [CNT_W-1:0]   cnt_r;

   logic [PTR_W-1:0]   pick_s;
   logic               wen_sel_s;
   logic [ADDR_W-1:0]  addr_sel_s;
   logic [DATA_W-1:0]  wdata_sel_s;
   logic               in_access_s;
   logic               expire_s;
   logic               finish_s;

   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
      logic [PTR_W-1:0] n;
      if (i == LAST_IDX) begin
         n = {PTR_W{1'b0}};
      end else begin
         n = i + 1'b1;
      end
      return n;
   endfunction

   // Search starts at the pointer so the previous winner becomes lowest priority.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] pick;
      logic             hit;
      idx  = p;
      pick = p;
      hit  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && r[idx]) begin
            pick = idx;
            hit  = 1'b1;
         end
         idx = next_idx(idx);
      end
      return pick;
   endfunction

   // Winner selection and request mux for the next grant.
   always_comb begin
      pick_s      = rr_pick(req, ptr_r);
      wen_sel_s   = 1'b0;
      addr_sel_s  = {ADDR_W{1'b0}};
      wdata_sel_s = {DATA_W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (pick_s == PTR_W'(i)) begin
            wen_sel_s   = wen[i];
            addr_sel_s  = addr[i*ADDR_W +: ADDR_W];
            wdata_sel_s = wdata[i*DATA_W +: DATA_W];
         end else begin
            wen_sel_s   = wen_sel_s;
            addr_sel_s  = addr_sel_s;
            wdata_sel_s = wdata_sel_s;
         end
      end
   end

   // Completion decode: a timeout finishes the access exactly like mem_ready, minus the data.
   always_comb begin
      in_access_s = (state_r == ACCESS);
      expire_s    = in_access_s && !mem_ready && (cnt_r == CNT_LAST);
      finish_s    = in_access_s && (mem_ready || (cnt_r == CNT_LAST));
      done        = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (finish_s && (win_r == PTR_W'(i))) begin
            done[i] = 1'b1;
         end else begin
            done[i] = 1'b0;
         end
      end
      if (in_access_s && mem_ready && !wen_r) begin
         rdata = mem_rdata;
      end else begin
         rdata = {DATA_W{1'b0}};
      end
      timeout_err = expire_s;
      mem_ren     = in_access_s & ~wen_r;
      mem_wen     = in_access_s & wen_r;
   end

   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;

   // Grant / access state machine with round-robin pointer and wait-state counter.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r <= IDLE;
         ptr_r   <= {PTR_W{1'b0}};
         win_r   <= {PTR_W{1'b0}};
         wen_r   <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if ((|req) && !halt) begin
                  win_r   <= pick_s;
                  wen_r   <= wen_sel_s;
                  addr_r  <= addr_sel_s;
                  wdata_r <= wdata_sel_s;
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= ACCESS;
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               if (finish_s) begin
                  ptr_r   <= next_idx(win_r);
                  state_r <= IDLE;
               end else begin
                  cnt_r   <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
